// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind a non-stallable multiplier: sums framed
// products and queues finished results in a 2-entry first-word-fall-through FIFO.
module mac_accumulator #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 16,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             prod_valid,
   input  logic [63:0]      prod,
   input  logic             prod_last,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [ACC_W-1:0] res_data,
   output logic [CNT_W-1:0] res_count,
   output logic             res_ovf,
   output logic             busy,
   output logic             drop_err
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ovf_reg, ovf_next;

   logic             push;
   logic [ACC_W-1:0] push_data;
   logic [CNT_W-1:0] push_cnt;
   logic             push_ovf;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_upd;
   logic [CNT_W-1:0] cnt_upd;
   logic             ovf_upd;

   assign prod_ext = ACC_W'(prod);
   assign sum      = {1'b0, acc_reg} + {1'b0, prod_ext};
   assign ovf_upd  = ovf_reg | sum[ACC_W];
   // Once saturated the accumulator stays pinned at all-ones until the frame ends
   assign acc_upd  = (SAT && ovf_upd) ? '1 : sum[ACC_W-1:0];
   assign cnt_upd  = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;
      push       = 1'b0;
      push_data  = acc_upd;
      push_cnt   = cnt_upd;
      push_ovf   = ovf_upd;
      if (clear) begin
         state_next = IDLE;
         acc_next   = '0;
         cnt_next   = '0;
         ovf_next   = 1'b0;
      end else if (prod_valid) begin
         case (state_reg)
            IDLE: begin
               if (prod_last) begin
                  push      = 1'b1;
                  push_data = prod_ext;
                  push_cnt  = CNT_W'(1);
                  push_ovf  = 1'b0;
               end else begin
                  acc_next   = prod_ext;
                  cnt_next   = CNT_W'(1);
                  ovf_next   = 1'b0;
                  state_next = ACCUM;
               end
            end
            ACCUM: begin
               if (prod_last) begin
                  push       = 1'b1;
                  acc_next   = '0;
                  cnt_next   = '0;
                  ovf_next   = 1'b0;
                  state_next = IDLE;
               end else begin
                  acc_next = acc_upd;
                  cnt_next = cnt_upd;
                  ovf_next = ovf_upd;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   logic [ACC_W-1:0] fifo_data [2];
   logic [CNT_W-1:0] fifo_cnt  [2];
   logic [1:0]       fifo_ovf;
   logic             rd_ptr, wr_ptr;
   logic [1:0]       occ_reg;
   logic             pop, full, wr_en;

   assign res_valid = (occ_reg != 2'd0);
   assign full      = (occ_reg == 2'd2);
   assign pop       = res_valid & res_ready;
   // A full FIFO still takes a result when its head leaves in the same cycle
   assign wr_en     = push & (~full | pop);
   assign res_data  = fifo_data[rd_ptr];
   assign res_count = fifo_cnt[rd_ptr];
   assign res_ovf   = fifo_ovf[rd_ptr];
   assign busy      = (state_reg == ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         ovf_reg      <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_cnt[0]  <= '0;
         fifo_cnt[1]  <= '0;
         fifo_ovf     <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         occ_reg      <= 2'd0;
         drop_err     <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
         if (wr_en) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_cnt[wr_ptr]  <= push_cnt;
            fifo_ovf[wr_ptr]  <= push_ovf;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (wr_en && !pop) begin
            occ_reg <= occ_reg + 2'd1;
         end else if (pop && !wr_en) begin
            occ_reg <= occ_reg - 2'd1;
         end
         if (clear) begin
            drop_err <= 1'b0;
         end else if (push && !wr_en) begin
            drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Drives three accumulator variants with one stream; a frame-level model feeds
// a scoreboard that a negedge monitor drains whenever a result is handed over.
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        prod_valid = 1'b0;
   logic [63:0] prod = 64'd0;
   logic        prod_last = 1'b0;
   logic        res_ready = 1'b0;

   always #5 clk = ~clk;

   logic        v0, v1, v2, o0, o1, o2, b0, b1, b2, e0, e1, e2;
   logic [71:0] d0;
   logic [63:0] d1, d2;
   logic [15:0] c0, c1;
   logic [2:0]  c2;

   mac_accumulator #(.ACC_W(72), .CNT_W(16), .SAT(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod(prod),
      .prod_last(prod_last), .res_ready(res_ready), .res_valid(v0), .res_data(d0),
      .res_count(c0), .res_ovf(o0), .busy(b0), .drop_err(e0));
   mac_accumulator #(.ACC_W(64), .CNT_W(16), .SAT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod(prod),
      .prod_last(prod_last), .res_ready(res_ready), .res_valid(v1), .res_data(d1),
      .res_count(c1), .res_ovf(o1), .busy(b1), .drop_err(e1));
   mac_accumulator #(.ACC_W(64), .CNT_W(3), .SAT(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid), .prod(prod),
      .prod_last(prod_last), .res_ready(res_ready), .res_valid(v2), .res_data(d2),
      .res_count(c2), .res_ovf(o2), .busy(b2), .drop_err(e2));

   typedef struct {
      logic [127:0] sum;
      int           n;
   } frame_t;

   frame_t       exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           occ = 0;
   bit           in_frame = 1'b0;
   bit           drop_exp = 1'b0;
   logic [127:0] f_sum = '0;
   int           f_n = 0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result a width-w accumulator should report for a frame whose exact sum is s
   function automatic logic [127:0] exp_data(logic [127:0] s, int w, bit sat);
      logic [127:0] lim;
      lim = 128'd1 << w;
      if (s >= lim) return sat ? lim - 128'd1 : (s & (lim - 128'd1));
      return s;
   endfunction

   function automatic logic [127:0] exp_ovf(logic [127:0] s, int w);
      return (s >= (128'd1 << w)) ? 128'd1 : 128'd0;
   endfunction

   function automatic logic [127:0] exp_cnt(int n, int cw);
      int lim;
      lim = (1 << cw) - 1;
      return (n > lim) ? 128'(lim) : 128'(n);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      occ      = 0;
      in_frame = 1'b0;
      drop_exp = 1'b0;
      f_sum    = '0;
      f_n      = 0;
   endtask

   // Applies the inputs seen at the clock edge just taken
   task automatic model_update();
      bit pop_now;
      bit accepted;
      pop_now  = (occ > 0) && res_ready;
      accepted = 1'b0;
      if (clear) begin
         in_frame = 1'b0;
         f_sum    = '0;
         f_n      = 0;
         drop_exp = 1'b0;
      end else if (prod_valid) begin
         if (!in_frame) begin
            f_sum = 128'(prod);
            f_n   = 1;
         end else begin
            f_sum = f_sum + 128'(prod);
            f_n   = f_n + 1;
         end
         if (prod_last) begin
            in_frame = 1'b0;
            if (occ < 2 || pop_now) begin
               exp_q.push_back('{f_sum, f_n});
               accepted = 1'b1;
            end else begin
               drop_exp = 1'b1;
            end
         end else begin
            in_frame = 1'b1;
         end
      end
      occ = occ - int'(pop_now) + int'(accepted);
   endtask

   task automatic step(bit v, logic [63:0] p, bit l, bit c);
      prod_valid = v;
      prod       = p;
      prod_last  = l;
      clear      = c;
      @(posedge clk);
      if (rst_n) model_update();
      #1;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_valid"}, v0, 0);
      chk({tag, "_data"}, d0, 0);
      chk({tag, "_data64"}, d1, 0);
      chk({tag, "_count"}, c0, 0);
      chk({tag, "_ovf"}, o0, 0);
      chk({tag, "_busy"}, b0, 0);
      chk({tag, "_drop"}, e0, 0);
   endtask

   always @(negedge clk) begin
      chk("valid0", v0, (occ > 0) ? 1 : 0);
      chk("valid1", v1, (occ > 0) ? 1 : 0);
      chk("valid2", v2, (occ > 0) ? 1 : 0);
      chk("busy0", b0, in_frame);
      chk("busy1", b1, in_frame);
      chk("busy2", b2, in_frame);
      chk("drop0", e0, drop_exp);
      chk("drop1", e1, drop_exp);
      chk("drop2", e2, drop_exp);
      if (v0 && res_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_result", 1, 0);
         end else begin
            frame_t f;
            f = exp_q.pop_front();
            $display("result sum=%0h n=%0d d0=%0h d1=%0h d2=%0h", f.sum, f.n, d0, d1, d2);
            chk("data0", d0, exp_data(f.sum, 72, 1'b1));
            chk("data1", d1, exp_data(f.sum, 64, 1'b1));
            chk("data2", d2, exp_data(f.sum, 64, 1'b0));
            chk("ovf0", o0, exp_ovf(f.sum, 72));
            chk("ovf1", o1, exp_ovf(f.sum, 64));
            chk("ovf2", o2, exp_ovf(f.sum, 64));
            chk("cnt0", c0, exp_cnt(f.n, 16));
            chk("cnt1", c1, exp_cnt(f.n, 16));
            chk("cnt2", c2, exp_cnt(f.n, 3));
         end
      end
   end

   initial begin
      logic [63:0] p;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n     = 1'b1;
      res_ready = 1'b1;

      // 3,5,7 frame and one-cycle result latency
      step(1, 64'd3, 0, 0);
      step(1, 64'd5, 0, 0);
      chk("lat_pre", v0, 0);
      step(1, 64'd7, 1, 0);
      chk("lat_valid", v0, 1);
      chk("sum357", d0, 72'd15);
      chk("cnt357", c0, 16'd3);
      chk("ovf357", o0, 0);
      step(0, 64'd0, 0, 0);

      step(1, 64'hFFFF_FFFE_0000_0001, 1, 0);
      chk("single_data", d0, 72'h00_FFFF_FFFE_0000_0001);
      chk("single_cnt", c0, 16'd1);
      step(0, 64'd0, 0, 0);

      // 2^63 + 2^63: fits in 72 bits, saturates / wraps in 64 bits
      step(1, 64'h8000_0000_0000_0000, 0, 0);
      step(1, 64'h8000_0000_0000_0000, 1, 0);
      chk("big_d0", d0, 72'h01_0000_0000_0000_0000);
      chk("big_o0", o0, 0);
      chk("sat_d1", d1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sat_o1", o1, 1);
      chk("wrap_d2", d2, 64'd0);
      chk("wrap_o2", o2, 1);
      step(0, 64'd0, 0, 0);

      // FIFO full: third result dropped
      res_ready = 1'b0;
      step(1, 64'd1, 1, 0);
      step(1, 64'd2, 1, 0);
      step(1, 64'd3, 1, 0);
      chk("drop_set", e0, 1);
      chk("full_head", d0, 72'd1);
      res_ready = 1'b1;
      step(0, 64'd0, 0, 0);
      chk("second_head", d0, 72'd2);
      step(0, 64'd0, 0, 0);
      chk("drained", v0, 0);

      // clear on a last product aborts the frame
      step(1, 64'd4, 0, 0);
      step(1, 64'd4, 0, 0);
      chk("busy_mid", b0, 1);
      step(1, 64'd4, 1, 1);
      chk("clr_busy", b0, 0);
      chk("clr_valid", v0, 0);
      chk("clr_drop", e0, 0);
      step(1, 64'd9, 1, 0);
      chk("after_clr", d0, 72'd9);
      step(0, 64'd0, 0, 0);

      // count saturation on the narrow counter
      for (int i = 0; i < 10; i++) step(1, 64'd1, (i == 9), 0);
      chk("cnt_wide", c0, 16'd10);
      chk("cnt_sat", c2, 3'd7);
      step(0, 64'd0, 0, 0);

      // asynchronous reset mid-frame with a result still queued
      res_ready = 1'b0;
      step(1, 64'd50, 1, 0);
      step(1, 64'd100, 0, 0);
      step(1, 64'd200, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("async_rst");
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      res_ready = 1'b1;
      step(1, 64'd6, 1, 0);
      chk("post_rst_data", d0, 72'd6);
      chk("post_rst_cnt", c0, 16'd1);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 2))
            0:       p = {$urandom, $urandom};
            1:       p = 64'($urandom_range(0, 1000));
            default: p = {32'hFFFF_FFFF, $urandom};
         endcase
         res_ready = ($urandom_range(0, 2) != 0);
         step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 49) == 0));
      end

      res_ready = 1'b1;
      for (int i = 0; i < 20 && (exp_q.size() > 0 || occ > 0); i++) step(0, 64'd0, 0, 0);
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_occ", occ, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
